// File: rtl/pad_oe_ssn_sched_if.sv
// Core-side OE request and pad-side OE result bundle for the SSN scheduler.
// Latency/backpressure: wires only; no flow control, oe_req is sampled every cycle.
interface pad_oe_ssn_sched_if #(
    parameter int NPAD = 64
);
    localparam int CW = $clog2(NPAD + 1);

    logic            en;
    logic            force_off;
    logic [NPAD-1:0] oe_req;
    logic [NPAD-1:0] oe_pad;
    logic            busy;
    logic [CW-1:0]   pend_cnt;

    modport master (
        output en,
        output force_off,
        output oe_req,
        input  oe_pad,
        input  busy,
        input  pend_cnt
    );

    modport slave (
        input  en,
        input  force_off,
        input  oe_req,
        output oe_pad,
        output busy,
        output pend_cnt
    );
endinterface

// File: rtl/pad_oe_ssn_sched.sv
// Applies core OE changes to the pads in batches of at most MAX_SW toggles, GAP idle cycles apart.
// Latency: 1 cycle to the first batch from IDLE; backpressure: none, pending changes live in oe_req^oe_pad.
module pad_oe_ssn_sched #(
    parameter int NPAD   = 64,
    parameter int MAX_SW = 8,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pad_oe_ssn_sched_if.slave bus
);
    localparam int CW = $clog2(NPAD + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_GAP  = 1'b1;
    localparam logic [GW-1:0] GAP_LD  = GW'(GAP);

    logic [0:0]      state;
    logic [GW-1:0]   cnt;
    logic [NPAD-1:0] oe_pad_q;
    logic [NPAD-1:0] diff;
    logic [NPAD-1:0] batch;
    logic [CW-1:0]   pend;

    assign diff = bus.oe_req ^ oe_pad_q;

    // One scan gives both the popcount and the lowest-index MAX_SW bits of diff.
    always_comb begin
        batch = '0;
        pend  = '0;
        for (int i = 0; i < NPAD; i++) begin
            if (diff[i]) begin
                if (int'(pend) < MAX_SW) begin
                    batch[i] = 1'b1;
                end
                pend = pend + CW'(1);
            end
        end
    end

    assign bus.oe_pad   = oe_pad_q;
    assign bus.pend_cnt = pend;
    assign bus.busy     = (|diff) | (state == ST_GAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oe_pad_q <= '0;
            cnt      <= '0;
            state    <= ST_IDLE;
        end else if (bus.force_off) begin
            oe_pad_q <= '0;
            cnt      <= '0;
            state    <= ST_IDLE;
        end else if (!bus.en) begin
            oe_pad_q <= bus.oe_req;
            cnt      <= '0;
            state    <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|diff) begin
                        oe_pad_q <= oe_pad_q ^ batch;
                        if (GAP != 0) begin
                            cnt   <= GAP_LD;
                            state <= ST_GAP;
                        end
                    end
                end
                default: begin
                    // Leaving on the edge that reaches zero puts the next batch GAP+1 edges after the last.
                    if (cnt != '0) begin
                        cnt <= cnt - GW'(1);
                    end
                    if (cnt <= GW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
